// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode (SRL/SRA/SLL/ROR) barrel shifter, one log-step per stage, LAT = log2(WIDTH)+2 enabled cycles.
// No backpressure: 'en' freezes the whole pipe; 'test' turns every data register into one scan chain.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     test,
  input  logic                     s_in,
  output logic                     s_out
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAT   = LOG2W + 2;

  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  logic [LAT-1:0][WIDTH-1:0] data_q, data_d, scan_d;
  logic [LAT-2:0][1:0]       op_q;
  logic [LOG2W-1:0]          fill_q;
  logic [LAT-1:0]            vld_q;
  logic [LOG2W-1:0]          amt_now;
  logic                      fill_in;

  assign fill_in   = (in_op == OP_SRA) & in_data[WIDTH-1];
  assign data_d[0] = (in_op == OP_SLL) ? bitrev(in_data) : in_data;
  assign scan_d[0] = {data_q[0][WIDTH-2:0], s_in};

  // Amount bit b is only consumed by stage LOG2W-b, so it rides a delay line of exactly that depth.
  for (genvar b = 0; b < LOG2W; b++) begin : g_amt
    localparam int D = LOG2W - b;
    logic [D-1:0] amt_q, amt_d;

    assign amt_d      = (amt_q << 1) | D'(in_amt[b]);
    assign amt_now[b] = amt_q[D-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)              amt_q <= '0;
      else if (!test && en) amt_q <= amt_d;
    end
  end

  for (genvar k = 1; k <= LOG2W; k++) begin : g_shift
    localparam int SH = WIDTH >> k;
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> SH);
    logic [WIDTH-1:0] src, rot, fil;

    assign src       = data_q[k-1];
    assign rot       = (src >> SH) | (src << (WIDTH - SH));
    assign fil       = (src >> SH) | ({WIDTH{fill_q[k-1]}} & FILL_MASK);
    assign data_d[k] = !amt_now[LOG2W-k] ? src : ((op_q[k-1] == OP_ROR) ? rot : fil);
  end

  assign data_d[LAT-1] = (op_q[LAT-2] == OP_SLL) ? bitrev(data_q[LAT-2]) : data_q[LAT-2];

  for (genvar k = 1; k < LAT; k++) begin : g_scan
    assign scan_d[k] = {data_q[k][WIDTH-2:0], data_q[k-1][WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= '0;
    else if (test) data_q <= scan_d;
    else if (en)   data_q <= data_d;
  end

  // Control state is frozen during scan so functional operation resumes with its beats intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      fill_q <= '0;
      vld_q  <= '0;
    end else if (!test && en) begin
      op_q   <= {op_q[LAT-3:0], in_op};
      fill_q <= {fill_q[LOG2W-2:0], fill_in};
      vld_q  <= {vld_q[LAT-2:0], in_valid};
    end
  end

  assign out_data  = data_q[LAT-1];
  assign out_valid = vld_q[LAT-1];
  assign s_out     = data_q[LAT-1][WIDTH-1];

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter. Supports logical right, arithmetic right, logical left and rotate-right modes.
- Carries a valid bit and a per-stage op/amount alongside the data. Has a global pipeline enable.
- All data pipeline registers are stitched into one serial scan chain for manufacturing test.
- Sits in the datapath as a drop-in multi-mode, any-width replacement for the fixed 32-bit right shifter.

Parameters:
- WIDTH, 32, data width; power of two, 4..64.
- LOG2W, derived localparam = $clog2(WIDTH); not overridable.
- LAT, derived localparam = LOG2W+2; input-to-output latency in enabled cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 = every stage holds.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  operand.
- in_amt  input  LOG2W  shift amount, 0..WIDTH-1.
- in_op  input  2  mode: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
- out_valid  output  1  result valid.
- out_data  output  WIDTH  result.
- test  input  1  scan mode select.
- s_in  input  1  scan serial in.
- s_out  output  1  scan serial out.

Behaviour:
- Stage structure: LAT register stages, S0..S(LAT-1).
  - S0 captures in_data, bit-reversed when in_op=SLL. S0 also captures the fill bit: in_data[WIDTH-1] for SRA, else 0.
  - S1..S(LOG2W): stage k shifts right by WIDTH>>k when the matching amount bit (in_amt[LOG2W-k]) is 1, i.e. MSB amount bit at S1 down to bit 0 at S(LOG2W).
    - Vacated bits take the fill bit for SRL/SRA/SLL.
    - Vacated bits take the wrapped low bits for ROR.
  - S(LOG2W+1) bit-reverses again when op=SLL. Its output drives out_data.
- Control pipeline: op, remaining amount bits, fill bit and valid travel with the data. Each stage uses only its own delayed copies, so a new, independent beat may enter every enabled cycle.
- Latency: a beat accepted at edge N (en=1) appears on out_data/out_valid after LAT enabled edges. For WIDTH=32, LAT=7. Throughput is one beat per enabled cycle.
- Invalid beats: data still flows when in_valid=0, but out_valid=0 for that slot. out_data is don't-care when out_valid=0.
- Amount 0: output equals input, in all modes.
- en=0: all data, control and valid registers hold. Outputs are stable.
- Reset (async, any time including mid-operation): all data, control, fill and valid registers clear to 0.
  - out_valid=0 and out_data=0 immediately.
  - In-flight beats are discarded.
  - The first beat after reset deassertion follows normal latency.
- Scan (test=1):
  - Overrides en.
  - All LAT×WIDTH data registers form one chain, shifting one bit per clk. S0[0] takes s_in; Sk[0] takes S(k-1)[WIDTH-1]; within a stage bit i takes bit i-1.
  - s_out = S(LAT-1)[WIDTH-1].
  - Control, fill and valid registers hold during scan.
  - test=0 resumes functional operation from whatever the chain holds.
- s_out is functional-don't-care when test=0. It remains equal to S(LAT-1)[WIDTH-1].
- rst has priority over test and en.

Test Plan (WIDTH=32, LAT=7):
1. SRL 0x80000000 amt 31, then SRA 0x80000000 amt 4, on consecutive cycles -> outputs 0x00000001 then 0xF8000000 on cycles 7 and 8, out_valid=1 on both.
2. SLL 0x00000001 amt 31 -> 0x80000000; ROR 0x00000001 amt 1 -> 0x80000000; ROR 0x12345678 amt 8 -> 0x78123456; SRA 0x7FFFFFFF amt 31 -> 0x00000000.
3. Stream 20 random beats back-to-back with in_valid toggling, random op/amt, en high -> each result matches the reference model 7 cycles later, in order; out_valid mirrors in_valid delayed by 7.
4. Stream beats, drop en for 3 cycles mid-stream -> out_data/out_valid frozen for those 3 cycles; no beat lost or duplicated; total latency becomes 10 cycles for the beats in flight.
5. Assert rst asynchronously (between edges) with 4 beats in flight -> out_valid=0 and out_data=0 before the next edge; after release, a new SRL 0xF0 amt 4 -> 0x0F after 7 cycles.
6. test=1, shift a 224-bit pattern (0xA5 repeating) through s_in -> pattern emerges on s_out starting at cycle 224, bit-exact. valid/control registers are unchanged after test returns to 0.
